// File: rtl/stage_cfg_ctrl_if.sv
// Control channel bundle for stage_cfg_ctrl: command in, per-stage CAM/action
// write port out, completion response, and the optional quiesce handshake.
interface stage_cfg_ctrl_if #(
   parameter int KEY_LEN    = 896,
   parameter int MASK_LEN   = 896,
   parameter int ACT_LEN    = 625,
   parameter int ADDR_W     = 4,
   parameter int NUM_STAGES = 5
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [2:0]            cmd_stage;
   logic [ADDR_W-1:0]     cmd_addr;
   logic [KEY_LEN-1:0]    cmd_key;
   logic [MASK_LEN-1:0]   cmd_mask;
   logic [ACT_LEN-1:0]    cmd_action;

   logic [KEY_LEN-1:0]    lookup_din;
   logic [MASK_LEN-1:0]   lookup_din_mask;
   logic [ADDR_W-1:0]     lookup_din_addr;
   logic [NUM_STAGES-1:0] lookup_din_en;
   logic [ACT_LEN-1:0]    action_data_in;
   logic [ADDR_W-1:0]     action_addr;
   logic [NUM_STAGES-1:0] action_en;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_err;
   logic                  cfg_hold;
   logic                  phv_inflight;

   modport master (
      output cmd_valid, cmd_op, cmd_stage, cmd_addr, cmd_key, cmd_mask, cmd_action,
      output rsp_ready, phv_inflight,
      input  cmd_ready, lookup_din, lookup_din_mask, lookup_din_addr, lookup_din_en,
      input  action_data_in, action_addr, action_en, rsp_valid, rsp_err, cfg_hold
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_stage, cmd_addr, cmd_key, cmd_mask, cmd_action,
      input  rsp_ready, phv_inflight,
      output cmd_ready, lookup_din, lookup_din_mask, lookup_din_addr, lookup_din_en,
      output action_data_in, action_addr, action_en, rsp_valid, rsp_err, cfg_hold
   );
endinterface

// File: rtl/stage_cfg_ctrl.sv
// Match-action table write sequencer; orders CAM/action writes so no stage sees a half-written entry.
// Optional macro STAGE_CFG_QUIESCE_EN adds a DRAIN state gated by phv_inflight and drives cfg_hold.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | cmd_ready high, waiting for a command
// S_DRAIN  | holding the parser until the stage pipelines are empty
// S_ACT_WR | one-cycle action RAM write
// S_CAM_WR | one-cycle CAM key/mask write
// S_CLR    | zeroing every entry of one stage, one address per cycle
// S_RESP   | rsp_valid held until rsp_ready
module stage_cfg_ctrl #(
   parameter int KEY_LEN    = 896,
   parameter int MASK_LEN   = 896,
   parameter int ACT_LEN    = 625,
   parameter int ADDR_W     = 4,
   parameter int NUM_STAGES = 5
) (
   input  logic             axis_clk,
   input  logic             areset,
   stage_cfg_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_DRAIN, S_ACT_WR, S_CAM_WR, S_CLR, S_RESP
   } state_e;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_INVAL = 2'd1;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   state_e                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [2:0]            stage_q, stage_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [KEY_LEN-1:0]    key_q, key_d;
   logic [MASK_LEN-1:0]   mask_q, mask_d;
   logic [ACT_LEN-1:0]    act_q, act_d;
   logic                  err_q, err_d;
   logic [ADDR_W-1:0]     cnt_q, cnt_d;

   logic                  cmd_ready_q, cmd_ready_d;
   logic [KEY_LEN-1:0]    lookup_din_q, lookup_din_d;
   logic [MASK_LEN-1:0]   lookup_din_mask_q, lookup_din_mask_d;
   logic [ADDR_W-1:0]     lookup_din_addr_q, lookup_din_addr_d;
   logic [NUM_STAGES-1:0] lookup_din_en_q, lookup_din_en_d;
   logic [ACT_LEN-1:0]    action_data_in_q, action_data_in_d;
   logic [ADDR_W-1:0]     action_addr_q, action_addr_d;
   logic [NUM_STAGES-1:0] action_en_q, action_en_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  cfg_hold_q, cfg_hold_d;

   logic                  accept;
   logic                  cmd_err;
   logic [NUM_STAGES-1:0] stage_oh;

   assign accept   = bus.cmd_valid && cmd_ready_q;
   assign cmd_err  = (bus.cmd_stage >= 3'(NUM_STAGES)) || (bus.cmd_op == OP_RSVD);
   assign stage_oh = NUM_STAGES'(1) << stage_d;

   function automatic state_e first_state(input logic [1:0] op);
      case (op)
         OP_WRITE: return S_ACT_WR;
         OP_INVAL: return S_CAM_WR;
         default:  return S_CLR;
      endcase
   endfunction

`ifndef STAGE_CFG_QUIESCE_EN
   logic unused_phv;
   assign unused_phv = bus.phv_inflight;
`endif

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         state_q           <= S_IDLE;
         op_q              <= '0;
         stage_q           <= '0;
         addr_q            <= '0;
         key_q             <= '0;
         mask_q            <= '0;
         act_q             <= '0;
         err_q             <= 1'b0;
         cnt_q             <= '0;
         cmd_ready_q       <= 1'b0;
         lookup_din_q      <= '0;
         lookup_din_mask_q <= '0;
         lookup_din_addr_q <= '0;
         lookup_din_en_q   <= '0;
         action_data_in_q  <= '0;
         action_addr_q     <= '0;
         action_en_q       <= '0;
         rsp_valid_q       <= 1'b0;
         rsp_err_q         <= 1'b0;
         cfg_hold_q        <= 1'b0;
      end else begin
         state_q           <= state_d;
         op_q              <= op_d;
         stage_q           <= stage_d;
         addr_q            <= addr_d;
         key_q             <= key_d;
         mask_q            <= mask_d;
         act_q             <= act_d;
         err_q             <= err_d;
         cnt_q             <= cnt_d;
         cmd_ready_q       <= cmd_ready_d;
         lookup_din_q      <= lookup_din_d;
         lookup_din_mask_q <= lookup_din_mask_d;
         lookup_din_addr_q <= lookup_din_addr_d;
         lookup_din_en_q   <= lookup_din_en_d;
         action_data_in_q  <= action_data_in_d;
         action_addr_q     <= action_addr_d;
         action_en_q       <= action_en_d;
         rsp_valid_q       <= rsp_valid_d;
         rsp_err_q         <= rsp_err_d;
         cfg_hold_q        <= cfg_hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = accept ? bus.cmd_op     : op_q;
      stage_d = accept ? bus.cmd_stage  : stage_q;
      addr_d  = accept ? bus.cmd_addr   : addr_q;
      key_d   = accept ? bus.cmd_key    : key_q;
      mask_d  = accept ? bus.cmd_mask   : mask_q;
      act_d   = accept ? bus.cmd_action : act_q;
      err_d   = accept ? cmd_err        : err_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (cmd_err) begin
                  state_d = S_RESP;
               end else begin
`ifdef STAGE_CFG_QUIESCE_EN
                  state_d = S_DRAIN;
`else
                  state_d = first_state(bus.cmd_op);
`endif
               end
            end
         end
         S_DRAIN:  if (!bus.phv_inflight) state_d = first_state(op_q);
         S_ACT_WR: state_d = (op_q == OP_WRITE) ? S_CAM_WR : S_RESP;
         S_CAM_WR: state_d = (op_q == OP_WRITE) ? S_RESP : S_ACT_WR;
         S_CLR:    if (&cnt_q) state_d = S_RESP;
         S_RESP:   if (bus.rsp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      // counter restarts from zero on every entry into CLR and stops at all-ones
      if (state_d == S_CLR) cnt_d = (state_q == S_CLR) ? cnt_q + 1'b1 : '0;
      else                  cnt_d = '0;
   end

   // outputs are a function of the next state so they appear registered in that state's cycle
   always_comb begin
      cmd_ready_d       = (state_d == S_IDLE);
      rsp_valid_d       = (state_d == S_RESP);
      rsp_err_d         = (state_d == S_RESP) && err_d;
      lookup_din_d      = '0;
      lookup_din_mask_d = '0;
      lookup_din_addr_d = '0;
      lookup_din_en_d   = '0;
      action_data_in_d  = '0;
      action_addr_d     = '0;
      action_en_d       = '0;
`ifdef STAGE_CFG_QUIESCE_EN
      cfg_hold_d        = (state_d inside {S_DRAIN, S_ACT_WR, S_CAM_WR, S_CLR});
`else
      cfg_hold_d        = 1'b0;
`endif
      case (state_d)
         S_ACT_WR: begin
            action_en_d      = stage_oh;
            action_addr_d    = addr_d;
            action_data_in_d = (op_d == OP_WRITE) ? act_d : '0;
         end
         S_CAM_WR: begin
            lookup_din_en_d   = stage_oh;
            lookup_din_addr_d = addr_d;
            lookup_din_d      = (op_d == OP_WRITE) ? key_d  : '0;
            lookup_din_mask_d = (op_d == OP_WRITE) ? mask_d : '0;
         end
         S_CLR: begin
            lookup_din_en_d   = stage_oh;
            action_en_d       = stage_oh;
            lookup_din_addr_d = cnt_d;
            action_addr_d     = cnt_d;
         end
         default: ;
      endcase
   end

   assign bus.cmd_ready       = cmd_ready_q;
   assign bus.lookup_din      = lookup_din_q;
   assign bus.lookup_din_mask = lookup_din_mask_q;
   assign bus.lookup_din_addr = lookup_din_addr_q;
   assign bus.lookup_din_en   = lookup_din_en_q;
   assign bus.action_data_in  = action_data_in_q;
   assign bus.action_addr     = action_addr_q;
   assign bus.action_en       = action_en_q;
   assign bus.rsp_valid       = rsp_valid_q;
   assign bus.rsp_err         = rsp_err_q;
   assign bus.cfg_hold        = cfg_hold_q;
endmodule

// File: tb/tb_stage_cfg_ctrl.sv
// Randomized bench for stage_cfg_ctrl against a per-command write schedule model.
// Build with +define+STAGE_CFG_QUIESCE_EN to exercise the DRAIN/cfg_hold behaviour.
module tb_stage_cfg_ctrl;
   localparam int KL = 896, ML = 896, AL = 625, AW = 4, NS = 5;
`ifdef STAGE_CFG_QUIESCE_EN
   localparam bit QUIESCE = 1'b1;
`else
   localparam bit QUIESCE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stage_cfg_ctrl_if #(.KEY_LEN(KL), .MASK_LEN(ML), .ACT_LEN(AL), .ADDR_W(AW), .NUM_STAGES(NS)) bus();

   stage_cfg_ctrl #(.KEY_LEN(KL), .MASK_LEN(ML), .ACT_LEN(AL), .ADDR_W(AW), .NUM_STAGES(NS)) dut (
      .axis_clk (clk),
      .areset   (rst),
      .bus      (bus)
   );

   int     n_vec = 0;
   int     n_err = 0;
   longint cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // expected schedule of one command, indexed by cycles after accept
   logic [NS-1:0] e_cen   [64];
   logic [NS-1:0] e_aen   [64];
   logic [AW-1:0] e_caddr [64];
   logic [AW-1:0] e_aaddr [64];
   bit            e_czero [64];
   bit            e_azero [64];
   int            e_rsp;
   bit            e_err;

   bit     prev_valid = 1'b0;
   longint prev_cyc;
   int     prev_gap;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [895:0] rand_wide();
      logic [895:0] v;
      for (int i = 0; i < 28; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic build(input int op, input int stage, input logic [AW-1:0] addr, input int p);
      logic [NS-1:0] oh;
      int d;
      for (int i = 0; i < 64; i++) begin
         e_cen[i] = '0; e_aen[i] = '0; e_caddr[i] = '0; e_aaddr[i] = '0;
         e_czero[i] = 1'b0; e_azero[i] = 1'b0;
      end
      e_err = (stage >= NS) || (op == 3);
      if (e_err) begin
         e_rsp = 1;
         return;
      end
      d  = QUIESCE ? ((p > 0) ? p : 1) : 0;
      oh = NS'(1) << stage;
      case (op)
         0: begin
            e_aen[1+d] = oh; e_aaddr[1+d] = addr;
            e_cen[2+d] = oh; e_caddr[2+d] = addr;
            e_rsp = 3 + d;
         end
         1: begin
            e_cen[1+d] = oh; e_caddr[1+d] = addr; e_czero[1+d] = 1'b1;
            e_aen[2+d] = oh; e_aaddr[2+d] = addr; e_azero[2+d] = 1'b1;
            e_rsp = 3 + d;
         end
         default: begin
            for (int i = 0; i < 16; i++) begin
               e_cen[1+d+i] = oh; e_aen[1+d+i] = oh;
               e_caddr[1+d+i] = AW'(i); e_aaddr[1+d+i] = AW'(i);
               e_czero[1+d+i] = 1'b1; e_azero[1+d+i] = 1'b1;
            end
            e_rsp = 17 + d;
         end
      endcase
   endtask

   // entered and left on a negedge
   task automatic run_cmd(input int op, input int stage, input logic [AW-1:0] addr,
                          input logic [KL-1:0] key, input logic [ML-1:0] mask,
                          input logic [AL-1:0] act, input int delay, input int p);
      int w = 0;
      build(op, stage, addr, p);
      bus.cmd_op       = 2'(op);
      bus.cmd_stage    = 3'(stage);
      bus.cmd_addr     = addr;
      bus.cmd_key      = key;
      bus.cmd_mask     = mask;
      bus.cmd_action   = act;
      bus.cmd_valid    = 1'b1;
      bus.phv_inflight = (p > 0);
      bus.rsp_ready    = (delay == 0);
      while (!bus.cmd_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!bus.cmd_ready) begin
         chk("accept_timeout", 64'(bus.cmd_ready), 64'd1);
         bus.cmd_valid = 1'b0;
         prev_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid  = 1'b0;
      bus.cmd_key    = rand_wide();
      bus.cmd_mask   = rand_wide();
      bus.cmd_action = AL'(rand_wide());
      bus.cmd_addr   = AW'($urandom);
      if (prev_valid) chk("accept_gap", 64'(cyc - prev_cyc), 64'(prev_gap));
      prev_valid = 1'b1;
      prev_cyc   = cyc;
      prev_gap   = e_rsp + delay + 1;
      for (int k = 1; k < e_rsp; k++) begin
         bus.phv_inflight = (k < p);
         chk("cam_en", 64'(bus.lookup_din_en), 64'(e_cen[k]));
         chk("act_en", 64'(bus.action_en), 64'(e_aen[k]));
         chk("rsp_valid_early", 64'(bus.rsp_valid), 64'd0);
         chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
         chk("cfg_hold_busy", 64'(bus.cfg_hold), 64'(QUIESCE));
         if (e_cen[k] != '0) begin
            chk("cam_addr", 64'(bus.lookup_din_addr), 64'(e_caddr[k]));
            chk("cam_key", 64'(bus.lookup_din === (e_czero[k] ? '0 : key)), 64'd1);
            chk("cam_mask", 64'(bus.lookup_din_mask === (e_czero[k] ? '0 : mask)), 64'd1);
         end
         if (e_aen[k] != '0) begin
            chk("act_addr", 64'(bus.action_addr), 64'(e_aaddr[k]));
            chk("act_data", 64'(bus.action_data_in === (e_azero[k] ? '0 : act)), 64'd1);
         end
         @(negedge clk);
      end
      for (int k = 0; k <= delay; k++) begin
         bus.phv_inflight = 1'b0;
         chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
         chk("rsp_err", 64'(bus.rsp_err), 64'(e_err));
         chk("cmd_ready_resp", 64'(bus.cmd_ready), 64'd0);
         chk("en_idle_resp", 64'({bus.lookup_din_en, bus.action_en}), 64'd0);
         chk("cfg_hold_resp", 64'(bus.cfg_hold), 64'd0);
         if (k == delay) bus.rsp_ready = 1'b1;
         @(negedge clk);
      end
      chk("rsp_valid_done", 64'(bus.rsp_valid), 64'd0);
      chk("cmd_ready_back", 64'(bus.cmd_ready), 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
      $fatal(1);
   end

   initial begin
      int op, stage, delay, p;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_stage = '0; bus.cmd_addr = '0;
      bus.cmd_key = '0; bus.cmd_mask = '0; bus.cmd_action = '0;
      bus.rsp_ready = 1'b1; bus.phv_inflight = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      chk("rst_enables", 64'({bus.lookup_din_en, bus.action_en}), 64'd0);
      chk("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.cfg_hold}), 64'd0);
      chk("rst_buses", 64'((bus.lookup_din | bus.lookup_din_mask) == '0
                           && bus.action_data_in == '0
                           && bus.lookup_din_addr == '0 && bus.action_addr == '0), 64'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'd1);

      run_cmd(0, 2, 4'd5, KL'(16'hABCD), rand_wide(), AL'(8'h1F), 0, 0);
      run_cmd(0, 1, 4'd9, rand_wide(), rand_wide(), AL'(rand_wide()), 0, 0);
      run_cmd(1, 0, 4'd3, rand_wide(), rand_wide(), AL'(rand_wide()), 0, 0);
      run_cmd(2, 4, 4'd7, rand_wide(), rand_wide(), AL'(rand_wide()), 0, 0);
      run_cmd(0, 6, 4'd1, rand_wide(), rand_wide(), AL'(rand_wide()), 0, 0);
      run_cmd(3, 1, 4'd1, rand_wide(), rand_wide(), AL'(rand_wide()), 0, 0);
      run_cmd(0, 3, 4'd15, rand_wide(), rand_wide(), AL'(rand_wide()), 10, 0);
      run_cmd(0, 2, 4'd0, rand_wide(), rand_wide(), AL'(rand_wide()), 0, 7);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: op = 0;
            4, 5:       op = 1;
            6:          op = 2;
            7:          op = 3;
            default:    op = 0;
         endcase
         stage = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
         delay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
         p     = int'($urandom_range(0, 4));
         run_cmd(op, stage, AW'($urandom), rand_wide(), rand_wide(), AL'(rand_wide()), delay, p);
      end

      // reset in the middle of a clear must abort it cleanly
      prev_valid = 1'b0;
      bus.cmd_op = 2'd2; bus.cmd_stage = 3'd4; bus.cmd_valid = 1'b1; bus.phv_inflight = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("clr_active", 64'(bus.lookup_din_en), 64'(5'b10000));
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_enables", 64'({bus.lookup_din_en, bus.action_en}), 64'd0);
      chk("midrst_ready", 64'({bus.cmd_ready, bus.rsp_valid}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_recover", 64'(bus.cmd_ready), 64'd1);
      chk("midrst_quiet", 64'({bus.lookup_din_en, bus.action_en, bus.rsp_valid}), 64'd0);
      run_cmd(0, 0, 4'd2, rand_wide(), rand_wide(), AL'(rand_wide()), 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
